// File: rtl/divu_pkg.sv
// Shared types and sizing for the iterative unsigned divider.
// The iteration count comes from how many restoring steps run per clock.
package divu_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_e;

    function automatic int iters_f(input int steps_per_cycle);
        return DIV_WIDTH / steps_per_cycle;
    endfunction

endpackage

// File: rtl/CarryLookaheadAdder.sv
// 32-bit adder: 4-bit lookahead groups, with the carry rippling between groups.
module CarryLookaheadAdder (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] sum_o,
    output logic        cout_o
);

    logic [31:0] g;
    logic [31:0] p;
    logic [32:0] c;

    assign g = a_i & b_i;
    assign p = a_i ^ b_i;

    always_comb begin
        c    = '0;
        c[0] = cin_i;
        for (int blk = 0; blk < 8; blk++) begin
            int b0;
            b0 = 4 * blk;
            c[b0+1] = g[b0] | (p[b0] & c[b0]);
            c[b0+2] = g[b0+1] | (p[b0+1] & g[b0]) | (p[b0+1] & p[b0] & c[b0]);
            c[b0+3] = g[b0+2] | (p[b0+2] & g[b0+1]) | (p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+2] & p[b0+1] & p[b0] & c[b0]);
            c[b0+4] = g[b0+3] | (p[b0+3] & g[b0+2]) | (p[b0+3] & p[b0+2] & g[b0+1])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & g[b0])
                    | (p[b0+3] & p[b0+2] & p[b0+1] & p[b0] & c[b0]);
        end
    end

    assign sum_o  = p ^ c[31:0];
    assign cout_o = c[32];

endmodule

// File: rtl/divu_step.sv
// One combinational restoring-division iteration.
// The trial subtraction is shifted - divisor, computed as shifted + ~divisor + 1 on the CLA.
module divu_step
    import divu_pkg::*;
(
    input  logic [DIV_WIDTH-1:0] rem_i,
    input  logic                 dividend_msb_i,
    input  logic [DIV_WIDTH-1:0] divisor_i,
    output logic [DIV_WIDTH-1:0] rem_next_o,
    output logic                 q_bit_o
);

    logic [DIV_WIDTH:0]   shifted;
    logic [DIV_WIDTH-1:0] diff;
    logic                 no_borrow;

    assign shifted = {rem_i, dividend_msb_i};

    CarryLookaheadAdder u_cla (
        .a_i   (shifted[DIV_WIDTH-1:0]),
        .b_i   (~divisor_i),
        .cin_i (1'b1),
        .sum_o (diff),
        .cout_o(no_borrow)
    );

    // The adder's carry-out is set exactly when shifted[31:0] >= divisor.
    assign q_bit_o    = shifted[DIV_WIDTH] | no_borrow;
    assign rem_next_o = q_bit_o ? diff : shifted[DIV_WIDTH-1:0];

endmodule

// File: rtl/divu_iterative.sv
// Multi-cycle unsigned 32-bit divider (DIVU/REMU) with valid/ready handshakes on both sides.
// state | meaning:  IDLE accept operands | BUSY iterate | DONE hold result until out_ready
module divu_iterative
    import divu_pkg::*;
#(
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [DIV_WIDTH-1:0] dividend,
    input  logic [DIV_WIDTH-1:0] divisor,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DIV_WIDTH-1:0] quotient,
    output logic [DIV_WIDTH-1:0] remainder,
    output logic                 div_by_zero
);

    localparam int              ITERS    = iters_f(STEPS_PER_CYCLE);
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(ITERS - 1);

    state_e               state_q, state_d;
    logic [DIV_WIDTH-1:0] dvd_q, dvd_d;
    logic [DIV_WIDTH-1:0] dvs_q, dvs_d;
    logic [DIV_WIDTH-1:0] rem_q, rem_d;
    logic [DIV_WIDTH-1:0] quo_q, quo_d;
    logic [DIV_WIDTH-1:0] rmd_q, rmd_d;
    logic                 dbz_q, dbz_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic [DIV_WIDTH-1:0] rem_step;
    logic [DIV_WIDTH-1:0] dvd_step;

    // Quotient bits enter the dividend register from the LSB as its MSBs are consumed.
    for (genvar k = 0; k < STEPS_PER_CYCLE; k++) begin : g_step
        logic [DIV_WIDTH-1:0] rem_in;
        logic [DIV_WIDTH-1:0] dvd_in;
        logic [DIV_WIDTH-1:0] rem_out;
        logic [DIV_WIDTH-1:0] dvd_out;
        logic                 q_bit;

        if (k == 0) begin : g_first
            assign rem_in = rem_q;
            assign dvd_in = dvd_q;
        end else begin : g_next
            assign rem_in = g_step[k-1].rem_out;
            assign dvd_in = g_step[k-1].dvd_out;
        end

        divu_step u_step (
            .rem_i         (rem_in),
            .dividend_msb_i(dvd_in[DIV_WIDTH-1]),
            .divisor_i     (dvs_q),
            .rem_next_o    (rem_out),
            .q_bit_o       (q_bit)
        );

        assign dvd_out = {dvd_in[DIV_WIDTH-2:0], q_bit};
    end

    assign rem_step = g_step[STEPS_PER_CYCLE-1].rem_out;
    assign dvd_step = g_step[STEPS_PER_CYCLE-1].dvd_out;

    always_comb begin
        state_d = state_q;
        dvd_d   = dvd_q;
        dvs_d   = dvs_q;
        rem_d   = rem_q;
        quo_d   = quo_q;
        rmd_d   = rmd_q;
        dbz_d   = dbz_q;
        cnt_d   = cnt_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    dvd_d   = dividend;
                    dvs_d   = divisor;
                    rem_d   = '0;
                    dbz_d   = (divisor == '0);
                    cnt_d   = CNT_INIT;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                dvd_d = dvd_step;
                rem_d = rem_step;
                if (cnt_q == '0) begin
                    quo_d   = dvd_step;
                    rmd_d   = rem_step;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            dvd_q   <= '0;
            dvs_q   <= '0;
            rem_q   <= '0;
            quo_q   <= '0;
            rmd_q   <= '0;
            dbz_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            rem_q   <= rem_d;
            quo_q   <= quo_d;
            rmd_q   <= rmd_d;
            dbz_q   <= dbz_d;
            cnt_q   <= cnt_d;
        end
    end

    assign in_ready    = (state_q == IDLE);
    assign out_valid   = (state_q == DONE);
    assign quotient    = quo_q;
    assign remainder   = rmd_q;
    assign div_by_zero = dbz_q;

endmodule
